// File: rtl/fft_out_capture.sv
// -----------------------------------------------------------------------------
// fft_out_capture
//
// Captures one frame of 2^AW complex FFT output samples into an internal
// buffer, holds the frame for the host to read at random addresses, and
// releases it on frame_ack. Samples arriving while a frame is held are
// discarded and counted in a saturating 8-bit counter.
//
// Build option:
//   FFT_CAP_BITREV_EN  - when defined, each sample is written at the AW-bit
//                        bit-reversal of its arrival index, so a bit-reversed
//                        FFT output stream is read back in natural order.
//                        When undefined, samples are stored in arrival order.
//
// Parameters:
//   DW  width of each real / imaginary sample (two's complement)
//   AW  log2 of the frame length
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   in_en        a sample is present on in_re / in_im this cycle
//   in_re/in_im  signed sample parts, stored bit-exact
//   rd_en        host read request (served only while a frame is held)
//   rd_addr      host read index
//   rd_valid     rd_re / rd_im carry the data of the previous accepted read
//   rd_re/rd_im  read data, held between accepted reads
//   frame_ready  a complete frame is held and readable (FULL)
//   frame_ack    host releases the held frame (ignored outside FULL)
//   busy         a frame capture is in progress (CAPTURE)
//   drop_cnt     saturating count of samples discarded while FULL
// -----------------------------------------------------------------------------
module fft_out_capture #(
   parameter int DW = 17,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_en,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   output logic [DW-1:0] rd_re,
   output logic [DW-1:0] rd_im,
   output logic          frame_ready,
   input  logic          frame_ack,
   output logic          busy,
   output logic [7:0]    drop_cnt
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FULL    = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_e          state_q,    state_d;
   logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;
   logic            rd_valid_q, rd_valid_d;
   logic [DW-1:0]   rd_re_q,    rd_re_d;
   logic [DW-1:0]   rd_im_q,    rd_im_d;

   // Frame buffer: real part in the upper half, imaginary in the lower half.
   logic [2*DW-1:0] mem_q [DEPTH];

   logic            wr_en;
   logic [AW-1:0]   wr_addr;

   // ---------------------------------------------------------------------------
   // Write address: arrival index, optionally bit-reversed
   // ---------------------------------------------------------------------------
`ifdef FFT_CAP_BITREV_EN
   always_comb begin
      wr_addr = '0;
      for (int i = 0; i < AW; i++) begin
         wr_addr[i] = wr_ptr_q[AW-1-i];
      end
   end
`else
   assign wr_addr = wr_ptr_q;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first so that no path
      // through the case leaves it unassigned and infers a latch.
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      drop_cnt_d = drop_cnt_q;
      wr_en      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_en) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               state_d  = ST_CAPTURE;
            end
         end

         ST_CAPTURE: begin
            if (in_en) begin
               wr_en    = 1'b1;
               // Wraps to zero on the last sample, ready for the next frame.
               wr_ptr_d = wr_ptr_q + AW'(1);
               if (wr_ptr_q == {AW{1'b1}}) begin
                  state_d = ST_FULL;
               end
            end
         end

         ST_FULL: begin
            // Incoming samples are discarded while the frame is held.
            if (in_en && (drop_cnt_q != 8'hFF)) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
            if (frame_ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Read path: one-cycle latency, data held when no read is accepted.
   // A read coinciding with frame_ack is still served because it is decided
   // from the current (FULL) state.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_valid_d = rd_en && (state_q == ST_FULL);
      rd_re_d    = rd_re_q;
      rd_im_d    = rd_im_q;
      if (rd_valid_d) begin
         rd_re_d = mem_q[rd_addr][2*DW-1:DW];
         rd_im_d = mem_q[rd_addr][DW-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Control registers (synchronous reset)
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         drop_cnt_q <= '0;
         rd_valid_q <= 1'b0;
         rd_re_q    <= '0;
         rd_im_q    <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         drop_cnt_q <= drop_cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_re_q    <= rd_re_d;
         rd_im_q    <= rd_im_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame buffer write
   // ---------------------------------------------------------------------------
   // NOTE: the buffer is deliberately not reset; a frame is only readable once
   // all of its entries have been written, so stale contents are never exposed
   // and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_addr] <= {in_re, in_im};
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign rd_valid    = rd_valid_q;
   assign rd_re       = rd_re_q;
   assign rd_im       = rd_im_q;
   assign frame_ready = (state_q == ST_FULL);
   assign busy        = (state_q == ST_CAPTURE);
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_fft_out_capture.sv
// -----------------------------------------------------------------------------
// tb_fft_out_capture
//
// Directed bench for fft_out_capture. A frame-level model (sample count,
// expected buffer contents, drop counter, read register) tracks what the
// outputs must be; a compare process checks every output on every falling
// edge. Literal checks at key points pin the model to hand-computed values.
// Works with or without FFT_CAP_BITREV_EN defined.
// -----------------------------------------------------------------------------
module tb_fft_out_capture;

   localparam int DW = 17;
   localparam int AW = 6;
   localparam int N  = 1 << AW;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_en;
   logic signed [DW-1:0] in_re;
   logic signed [DW-1:0] in_im;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic                 rd_valid;
   logic signed [DW-1:0] rd_re;
   logic signed [DW-1:0] rd_im;
   logic                 frame_ready;
   logic                 frame_ack;
   logic                 busy;
   logic [7:0]           drop_cnt;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   fft_out_capture #(.DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_en       (in_en),
      .in_re       (in_re),
      .in_im       (in_im),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_re       (rd_re),
      .rd_im       (rd_im),
      .frame_ready (frame_ready),
      .frame_ack   (frame_ack),
      .busy        (busy),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Frame-level model
   // ---------------------------------------------------------------------------
   int m_count = 0;   // samples held in the current frame, 64 = frame complete
   int m_drop  = 0;
   bit m_rv    = 1'b0;
   int m_rre   = 0;
   int m_rim   = 0;
   int m_re [N];
   int m_im [N];

   function automatic int store_index(input int k);
      int r;
`ifdef FFT_CAP_BITREV_EN
      r = 0;
      for (int i = 0; i < AW; i++) r += ((k >> i) & 1) << (AW - 1 - i);
`else
      r = k;
`endif
      return r;
   endfunction

   always @(posedge clk) begin
      bit full;
      full = (m_count == N);
      if (rst) begin
         m_count = 0;
         m_drop  = 0;
         m_rv    = 1'b0;
         m_rre   = 0;
         m_rim   = 0;
      end else begin
         m_rv = rd_en && full;
         if (m_rv) begin
            m_rre = m_re[rd_addr];
            m_rim = m_im[rd_addr];
         end
         if (in_en) begin
            if (full) begin
               if (m_drop < 255) m_drop++;
            end else begin
               m_re[store_index(m_count)] = in_re;
               m_im[store_index(m_count)] = in_im;
               m_count++;
            end
         end
         if (full && frame_ack) m_count = 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("frame_ready", frame_ready, (m_count == N) ? 1 : 0);
         check("busy",        busy, (m_count > 0 && m_count < N) ? 1 : 0);
         check("drop_cnt",    drop_cnt, m_drop);
         check("rd_valid",    rd_valid, m_rv);
         check("rd_re",       rd_re, m_rre);
         check("rd_im",       rd_im, m_rim);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers: inputs are applied 1 time unit after a rising edge and
   // held for one full cycle.
   // ---------------------------------------------------------------------------
   task automatic drive(input logic r, input logic e, input int re, input int im,
                        input logic rde, input int addr, input logic ack);
      rst       = r;
      in_en     = e;
      in_re     = DW'(re);
      in_im     = DW'(im);
      rd_en     = rde;
      rd_addr   = AW'(addr);
      frame_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int re, input int im);
      drive(1'b0, 1'b1, re, im, 1'b0, 0, 1'b0);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic read(input int addr);
      drive(1'b0, 1'b0, 0, 0, 1'b1, addr, 1'b0);
   endtask

   // Hand-computed literals that differ between the two build options.
`ifdef FFT_CAP_BITREV_EN
   localparam int A5_RE   = 40;     // addr 5 holds sample bitrev(5) = 40
   localparam int A1_RE   = 32;
   localparam int A10_RE  = 2020;   // addr 10 holds sample 20 of fresh frame
   localparam int A10_IM  = -60;
`else
   localparam int A5_RE   = 5;
   localparam int A1_RE   = 1;
   localparam int A10_RE  = 2010;
   localparam int A10_IM  = -30;
`endif

   initial begin
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      cmp_en = 1'b1;
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      check("reset_frame_ready", frame_ready, 0);
      check("reset_busy",        busy, 0);
      check("reset_rd_valid",    rd_valid, 0);
      check("reset_rd_re",       rd_re, 0);
      check("reset_drop_cnt",    drop_cnt, 0);
      idle();

      // Frame A: in_re = k, in_im = -k; frame_ack and rd_en during capture
      // are ignored.
      for (int k = 0; k < N; k++) begin
         if (k == 10) drive(1'b0, 1'b1, k, -k, 1'b1, 3, 1'b1);
         else sample(k, -k);
         if (k == 0)     check("busy_first_sample", busy, 1);
         if (k == N - 2) check("ready_before_last", frame_ready, 0);
      end
      check("ready_after_last", frame_ready, 1);
      check("busy_after_last",  busy, 0);
      read(5);
      check("a5_valid", rd_valid, 1);
      check("a5_re",    rd_re, A5_RE);
      check("a5_im",    rd_im, -A5_RE);
      read(1);
      check("a1_re", rd_re, A1_RE);
      read(63);
      check("a63_re", rd_re, 63);
      idle();
      check("valid_one_cycle", rd_valid, 0);
      for (int a = 0; a < N; a++) read(a);

      // 300 samples while FULL: all dropped, counter saturates.
      for (int k = 0; k < 300; k++) sample(7777 + k, -7777);
      check("drop_saturated", drop_cnt, 255);
      read(5);
      check("a5_re_after_drops", rd_re, A5_RE);
      for (int a = 0; a < N; a += 7) read(a);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
      check("ack_ready_low", frame_ready, 0);
      check("ack_busy_low",  busy, 0);
      check("drop_kept",     drop_cnt, 255);

      // 40 samples with gaps, then reset (with competing inputs).
      for (int k = 0; k < 40; k++) begin
         sample(1000 + k, k);
         drive(1'b0, 1'b0, 0, 0, 1'b1, k, 1'b1);
      end
      check("gapped_busy", busy, 1);
      drive(1'b1, 1'b1, 555, 555, 1'b1, 0, 1'b1);
      check("rst_busy",     busy, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_rd_re",    rd_re, 0);
      for (int k = 0; k < N; k++) begin
         sample(2000 + k, -3 * k);
         if (k == N - 2) check("fresh_ready_before_last", frame_ready, 0);
      end
      check("fresh_ready_after_last", frame_ready, 1);
      for (int a = 0; a < N; a++) read(a);

      // Read and release in the same cycle.
      drive(1'b0, 1'b0, 0, 0, 1'b1, 10, 1'b1);
      check("rdack_valid", rd_valid, 1);
      check("rdack_re",    rd_re, A10_RE);
      check("rdack_im",    rd_im, A10_IM);
      check("rdack_ready", frame_ready, 0);
      read(10);
      check("after_release_valid", rd_valid, 0);
      check("after_release_hold",  rd_re, A10_RE);

      // Extreme values at sample 0 (stored at address 0 either way).
      sample(65535, -65536);
      for (int k = 1; k < N; k++) sample(-k, k - 100);
      read(0);
      check("ext_re", rd_re, 65535);
      check("ext_im", rd_im, -65536);
      for (int a = N - 4; a < N; a++) read(a);
      idle();
      idle();

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
